// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bin2bcd_seq_if                                                |
// | Description : Request/result bundle for the sequential binary-to-BCD        |
// |               converter. The requester (master) drives start/bin; the      |
// |               converter (slave) returns busy/done and the formatted result. |
// | Signals     : start, bin        - request (master -> slave)                 |
// |               busy, done        - status  (slave -> master)                 |
// |               sign, bcd,        - result  (slave -> master)                 |
// |               ndigits, overflow                                             |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  localparam int NDW = $clog2(DIGITS + 1);

  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic                sign;
  logic [4*DIGITS-1:0] bcd;
  logic [NDW-1:0]      ndigits;
  logic                overflow;

  modport master (
    output start, bin,
    input  busy, done, sign, bcd, ndigits, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, sign, bcd, ndigits, overflow
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bin2bcd_seq                                                   |
// | Description : Signed two's-complement to BCD converter using a double-     |
// |               dabble engine, one add-3/shift step per clock. Reports sign, |
// |               significant-digit count and overflow for the LCD formatter.  |
// | Ports       : clk  - rising-edge clock                                      |
// |               rst  - synchronous active-high reset                          |
// |               bus  - bin2bcd_seq_if.slave (start/bin in; busy/done/sign/    |
// |                      bcd/ndigits/overflow out, all registered)              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);

  localparam int NDW    = $clog2(DIGITS + 1);
  localparam int c_cntw = $clog2(WIDTH + 1);
  localparam int c_bw   = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;          // magnitude being shifted out MSB first
  logic [c_bw-1:0]     acc_q, acc_d;          // BCD shift register
  logic [c_cntw-1:0]   cnt_q, cnt_d;          // remaining steps
  logic                ovf_acc_q, ovf_acc_d;  // sticky: a bit left the top digit
  logic                sign_acc_q, sign_acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sign_q, sign_d;
  logic [c_bw-1:0]     bcd_q, bcd_d;
  logic [NDW-1:0]      ndigits_q, ndigits_d;
  logic                overflow_q, overflow_d;

  logic [c_bw-1:0]     w_acc_adj;
  logic [c_bw-1:0]     w_acc_shift;
  logic                w_ovf_step;
  logic [NDW-1:0]      w_nd;
  logic [WIDTH-1:0]    w_bin_abs;

  // Plain modular negation: the most negative input wraps to 2^(WIDTH-1),
  // which is exactly its magnitude when read as unsigned.
  assign w_bin_abs = bus.bin[WIDTH-1] ? ((~bus.bin) + WIDTH'(1)) : bus.bin;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      assign w_acc_adj[4*k +: 4] = (acc_q[4*k +: 4] > 4'd4) ? (acc_q[4*k +: 4] + 4'd3)
                                                             : acc_q[4*k +: 4];
    end
  endgenerate

  // The bit dropped off the top digit carries a multiple of 10^DIGITS, so
  // the register keeps the magnitude mod 10^DIGITS and the lost bit flags it.
  assign w_acc_shift = {w_acc_adj[c_bw-2:0], mag_q[WIDTH-1]};
  assign w_ovf_step  = ovf_acc_q | w_acc_adj[c_bw-1];

  // Significant digits of the final step's value; overflow forces the cap.
  always_comb begin
    w_nd = NDW'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (w_acc_shift[4*k +: 4] != 4'd0) begin
        w_nd = NDW'(k + 1);
      end
    end
    if (w_ovf_step) begin
      w_nd = NDW'(DIGITS);
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    sign_acc_d = sign_acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    ndigits_d  = ndigits_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mag_d      = w_bin_abs;
          sign_acc_d = bus.bin[WIDTH-1];
          acc_d      = '0;
          cnt_d      = c_cntw'(WIDTH);
          ovf_acc_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        acc_d     = w_acc_shift;
        ovf_acc_d = w_ovf_step;
        cnt_d     = cnt_q - c_cntw'(1);
        if (cnt_q == c_cntw'(1)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          sign_d     = sign_acc_q;
          bcd_d      = w_acc_shift;
          ndigits_d  = w_nd;
          overflow_d = w_ovf_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      sign_acc_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      ndigits_q  <= NDW'(1);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      sign_acc_q <= sign_acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      ndigits_q  <= ndigits_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sign     = sign_q;
  assign bus.bcd      = bcd_q;
  assign bus.ndigits  = ndigits_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_bin2bcd_seq                                                |
// | Description : Self-checking bench for bin2bcd_seq. Two instances: 32-bit/   |
// |               10-digit (main) and 16-bit/4-digit (overflow cases). Accepted |
// |               requests push an arithmetic reference result to a queue; each |
// |               done pops and compares it, including the accept-to-done gap. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_bin2bcd_seq;

  typedef struct {
    logic        sign;
    logic [39:0] bcd;
    logic [3:0]  nd;
    logic        ovf;
    int unsigned t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(32), .DIGITS(10)) if32 ();
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(4))  if16 ();

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4))  u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned cyc     = 0;
  int          done32_cnt = 0;
  logic        done32_prev = 1'b0;
  logic        done16_prev = 1'b0;
  exp_t        q32[$];
  exp_t        q16[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: decimal arithmetic on the sign-corrected magnitude.
  function automatic exp_t model(input logic [31:0] raw, input int w, input int d);
    exp_t e;
    longint unsigned v, mag, lim, m;
    v      = 64'(raw) & ((64'd1 << w) - 64'd1);
    e.sign = raw[w-1];
    mag    = e.sign ? ((64'd1 << w) - v) : v;
    lim    = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    m     = mag % lim;
    e.bcd = '0;
    e.nd  = 4'd1;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      if ((m % 10) != 0) e.nd = 4'(i + 1);
      m = m / 10;
    end
    if (e.ovf) e.nd = 4'(d);
    e.t_acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance: start seen while idle (busy low) and not in reset.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      q32.delete();
      q16.delete();
    end else begin
      if (if32.start && !if32.busy) begin
        e = model(if32.bin, 32, 10);
        e.t_acc = cyc + 1;
        q32.push_back(e);
      end
      if (if16.start && !if16.busy) begin
        e = model({16'h0, if16.bin}, 16, 4);
        e.t_acc = cyc + 1;
        q16.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if32.done) begin
      done32_cnt++;
      check("w32_done_expected", 64'(q32.size() != 0), 64'd1);
      check("w32_done_single", 64'(done32_prev), 64'd0);
      check("w32_busy_at_done", 64'(if32.busy), 64'd0);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        check("w32_sign", 64'(if32.sign), 64'(e.sign));
        check("w32_bcd", 64'(if32.bcd), 64'(e.bcd));
        check("w32_ndigits", 64'(if32.ndigits), 64'(e.nd));
        check("w32_overflow", 64'(if32.overflow), 64'(e.ovf));
        check("w32_latency", 64'(cyc - e.t_acc), 64'd32);
      end
    end
    if (if16.done) begin
      check("w16_done_expected", 64'(q16.size() != 0), 64'd1);
      check("w16_done_single", 64'(done16_prev), 64'd0);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("w16_sign", 64'(if16.sign), 64'(e.sign));
        check("w16_bcd", 64'(if16.bcd), 64'(e.bcd[15:0]));
        check("w16_ndigits", 64'(if16.ndigits), 64'(e.nd[2:0]));
        check("w16_overflow", 64'(if16.overflow), 64'(e.ovf));
        check("w16_latency", 64'(cyc - e.t_acc), 64'd16);
      end
    end
    done32_prev <= if32.done;
    done16_prev <= if16.done;
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q32.size() != 0 || if32.busy || q16.size() != 0 || if16.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q32.size() == 0 && !if32.busy && q16.size() == 0 && !if16.busy), 64'd1);
  endtask

  task automatic run32(input logic [31:0] v);
    @(negedge clk);
    if32.bin   = v;
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    drain(60);
  endtask

  task automatic run16(input logic [15:0] v);
    @(negedge clk);
    if16.bin   = v;
    if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    drain(40);
  endtask

  task automatic check_reset_state32(input string tag);
    check({tag, "_busy"}, 64'(if32.busy), 64'd0);
    check({tag, "_done"}, 64'(if32.done), 64'd0);
    check({tag, "_sign"}, 64'(if32.sign), 64'd0);
    check({tag, "_bcd"}, 64'(if32.bcd), 64'd0);
    check({tag, "_ndigits"}, 64'(if32.ndigits), 64'd1);
    check({tag, "_overflow"}, 64'(if32.overflow), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    exp_t e;
    if32.start = 1'b0;
    if32.bin   = '0;
    if16.start = 1'b0;
    if16.bin   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state32("rst32");
    check("rst16_ndigits", 64'(if16.ndigits), 64'd1);
    check("rst16_bcd", 64'(if16.bcd), 64'd0);
    rst = 1'b0;

    // Zero, minimum negative, extremes
    run32(32'h0000_0000);
    run32(32'h8000_0000);
    run32(32'h7FFF_FFFF);
    run32(32'hFFFF_FFFF);

    // Overflow behaviour on the narrow instance
    run16(16'd12345);
    run16(16'd9999);
    run16(16'hFC18);   // -1000
    run16(16'h8000);   // -32768 -> overflow, 2768

    // Start held high: back-to-back conversions of 42
    @(negedge clk);
    if32.bin   = 32'd42;
    if32.start = 1'b1;
    base = done32_cnt;
    n = 0;
    while (done32_cnt < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_start_three_dones", 64'(done32_cnt >= base + 3), 64'd1);
    if32.start = 1'b0;
    drain(60);

    // Start pulse while busy is ignored
    @(negedge clk);
    if32.bin   = 32'd42;
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    repeat (5) @(negedge clk);
    if32.bin   = 32'd7;
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    drain(60);
    repeat (3) @(negedge clk);
    e = model(32'd42, 32, 10);
    check("ignored_start_bcd", 64'(if32.bcd), 64'(e.bcd));

    // Reset in the middle of a conversion
    @(negedge clk);
    if32.bin   = -32'sd5;
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst_busy_before", 64'(if32.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state32("midrst");
    base = done32_cnt;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(done32_cnt - base), 64'd0);
    run32(32'd99);
    check("after_rst_ndigits", 64'(if32.ndigits), 64'd2);

    // Randomized sweep
    for (int i = 0; i < 1000; i++) run32($urandom);
    for (int i = 0; i < 100; i++) run16(16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, handshaked binary-to-BCD converter for the LCD board display path. It converts one signed two's-complement value per request using a double-dabble engine: one add-3/shift step per clock. Compared with a fully combinational converter, it trades latency for a small area. It sits between the floating-point adder/subtractor result registers and the LCD character driver, and also reports sign, significant-digit count and overflow for display formatting.

## Interface
- WIDTH, 32, bit width of the two's-complement input (≥4).
- DIGITS, 10, number of BCD digits produced (≥1).
- NDW, $clog2(DIGITS+1), width of the digit-count output (derived; not for override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  WIDTH  two's-complement value; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new results are valid.
- sign  out  1  sign of the last converted value (1 = negative).
- bcd  out  4*DIGITS  magnitude in BCD, packed; digit k is at bcd[4k+3:4k], digit 0 least significant.
- ndigits  out  NDW  count of significant digits; 1 when the magnitude is 0; capped at DIGITS.
- overflow  out  1  magnitude ≥ 10^DIGITS; bcd then holds the magnitude mod 10^DIGITS.

## Operation
- States: IDLE and CONV.
- IDLE, start=1 on an edge:
  - mag ← |bin| as a WIDTH-bit unsigned value; sign_r ← bin[WIDTH-1].
  - Internal BCD shift register ← 0; step counter ← WIDTH; ovf_r ← 0.
  - busy ← 1; state → CONV.
- IDLE, start=0: hold; outputs keep the last result.
- CONV, each edge, performed as one combined step:
  - Every BCD digit > 4 gets +3.
  - {bcd_reg, mag} shifts left by 1. The bit leaving the top of bcd_reg ORs into ovf_r.
  - Counter decrements.
- CONV, the edge where the counter goes 1→0:
  - Register the shifted bcd_reg into bcd, sign_r into sign, the final ovf_r into overflow, and the computed count into ndigits.
  - done ← 1 for one cycle; busy ← 0; state → IDLE.
- Magnitude rule: -2^(WIDTH-1) yields unsigned magnitude 2^(WIDTH-1). Negation must not sign-extend or saturate.
- ndigits = index of the most significant nonzero digit + 1, or 1 if all digits are zero. When overflow=1, ndigits = DIGITS.
- sign is reported even for a zero magnitude. The input cannot produce -0, so sign=0 whenever bin=0.
- start while busy=1 is ignored, not queued. bin changes during CONV have no effect.
- Only the result of an accepted request updates sign, bcd, ndigits and overflow, and only at its done edge.

## Timing
- Reset (rst=1 on an edge, any state, including mid-CONV):
  - State → IDLE; busy=0, done=0, sign=0, bcd=0, ndigits=1, overflow=0.
  - Internal registers are cleared. An aborted conversion produces no done.
  - rst has priority over start on the same edge.
- Latency: the request is accepted on edge E0. busy is high after E0 through E0+WIDTH-1. On edge E0+WIDTH, done=1, busy=0 and the results are valid.
  - Result latency is WIDTH clocks; throughput is one conversion per WIDTH+1 clocks.
- done and start may be high in the same cycle. Because the FSM is in IDLE that cycle, the new request is accepted on the next edge, back-to-back.
- done is never high for two consecutive cycles except by back-to-back requests, which are at least WIDTH+1 cycles apart.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Zero, and minimum negative:
  - bin=0, start pulse → after 32 clocks done=1, sign=0, bcd=0, ndigits=1, overflow=0.
  - bin=32'h8000_0000 → sign=1, bcd=2147483648, ndigits=10, overflow=0.
- Extremes:
  - bin=32'h7FFF_FFFF → sign=0, bcd=2147483647, ndigits=10.
  - bin=32'hFFFF_FFFF → sign=1, bcd=1, ndigits=1.
- Overflow (WIDTH=16, DIGITS=4):
  - bin=12345 → overflow=1, bcd=2345, ndigits=4.
  - bin=9999 → overflow=0, ndigits=4.
  - bin=-1000 → sign=1, bcd=1000, ovf=0.
- Handshake:
  - With bin=42, start held high continuously → done pulses every 33 clocks; each done shows bcd=42.
  - A single start pulse mid-busy with bin=7 is ignored; the result stays at 42.
- Reset mid-conversion:
  - Start bin=-5, assert rst at busy cycle 10 → next cycle busy=0, bcd=0, ndigits=1, sign=0; no done is ever pulsed.
  - New start bin=99 → done after 32 clocks with bcd=99, ndigits=2.
- Randomized sweep: 1000 random 32-bit values, compared against a reference model of sign, |value| in decimal, and digit count.
  - Every done appears exactly 32 clocks after its accepting edge.
